// File: rtl/morse_keyer.sv
// morse_keyer: turns ASCII characters received over a valid/ready handshake
// into a Morse on/off key stream on a single registered LED bit. One unit of
// Morse time is UNIT_TICKS clock cycles; dots are 1 unit, dashes 3 units,
// element gaps 1 unit, character gaps 3 units and a space adds 4 more units.
module morse_keyer #(
  parameter int UNIT_TICKS = 1600000,
  parameter int CNT_W      = $clog2(3*UNIT_TICKS+1)
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       led,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    EGAP,
    CGAP,
    WGAP
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(UNIT_TICKS - 1);

  state_t state;
  state_t state_next;

  logic [7:0] upper_char;
  logic [2:0] rom_len;
  logic [4:0] rom_bits;
  logic       is_symbol;
  logic       is_space;
  logic       accept;

  logic [4:0]       elem_bits;
  logic [2:0]       elem_left;
  logic [CNT_W-1:0] tick_cnt;
  logic [1:0]       unit_cnt;
  logic             done;
  logic             next_dash;
  logic [1:0]       entry_units;

  assign accept = char_valid && char_ready;
  assign done   = (tick_cnt == '0) && (unit_cnt == 2'd0);

  // Fold lowercase onto uppercase and look up the Morse pattern; a zero length marks an unsupported code
  always_comb begin
    upper_char = char_data;
    if (char_data >= 8'h61 && char_data <= 8'h7A) begin
      upper_char = char_data - 8'h20;
    end
    is_space = (char_data == 8'h20);
    {rom_len, rom_bits} = {3'd0, 5'b00000};
    case (upper_char)
      8'h41: {rom_len, rom_bits} = {3'd2, 5'b01000};
      8'h42: {rom_len, rom_bits} = {3'd4, 5'b10000};
      8'h43: {rom_len, rom_bits} = {3'd4, 5'b10100};
      8'h44: {rom_len, rom_bits} = {3'd3, 5'b10000};
      8'h45: {rom_len, rom_bits} = {3'd1, 5'b00000};
      8'h46: {rom_len, rom_bits} = {3'd4, 5'b00100};
      8'h47: {rom_len, rom_bits} = {3'd3, 5'b11000};
      8'h48: {rom_len, rom_bits} = {3'd4, 5'b00000};
      8'h49: {rom_len, rom_bits} = {3'd2, 5'b00000};
      8'h4A: {rom_len, rom_bits} = {3'd4, 5'b01110};
      8'h4B: {rom_len, rom_bits} = {3'd3, 5'b10100};
      8'h4C: {rom_len, rom_bits} = {3'd4, 5'b01000};
      8'h4D: {rom_len, rom_bits} = {3'd2, 5'b11000};
      8'h4E: {rom_len, rom_bits} = {3'd2, 5'b10000};
      8'h4F: {rom_len, rom_bits} = {3'd3, 5'b11100};
      8'h50: {rom_len, rom_bits} = {3'd4, 5'b01100};
      8'h51: {rom_len, rom_bits} = {3'd4, 5'b11010};
      8'h52: {rom_len, rom_bits} = {3'd3, 5'b01000};
      8'h53: {rom_len, rom_bits} = {3'd3, 5'b00000};
      8'h54: {rom_len, rom_bits} = {3'd1, 5'b10000};
      8'h55: {rom_len, rom_bits} = {3'd3, 5'b00100};
      8'h56: {rom_len, rom_bits} = {3'd4, 5'b00010};
      8'h57: {rom_len, rom_bits} = {3'd3, 5'b01100};
      8'h58: {rom_len, rom_bits} = {3'd4, 5'b10010};
      8'h59: {rom_len, rom_bits} = {3'd4, 5'b10110};
      8'h5A: {rom_len, rom_bits} = {3'd4, 5'b11000};
      8'h30: {rom_len, rom_bits} = {3'd5, 5'b11111};
      8'h31: {rom_len, rom_bits} = {3'd5, 5'b01111};
      8'h32: {rom_len, rom_bits} = {3'd5, 5'b00111};
      8'h33: {rom_len, rom_bits} = {3'd5, 5'b00011};
      8'h34: {rom_len, rom_bits} = {3'd5, 5'b00001};
      8'h35: {rom_len, rom_bits} = {3'd5, 5'b00000};
      8'h36: {rom_len, rom_bits} = {3'd5, 5'b10000};
      8'h37: {rom_len, rom_bits} = {3'd5, 5'b11000};
      8'h38: {rom_len, rom_bits} = {3'd5, 5'b11100};
      8'h39: {rom_len, rom_bits} = {3'd5, 5'b11110};
      default: {rom_len, rom_bits} = {3'd0, 5'b00000};
    endcase
    is_symbol = (rom_len != 3'd0);
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each timed state leaves once its unit/tick counters run out
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_symbol) begin
            state_next = MARK;
          end else if (is_space) begin
            state_next = WGAP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      MARK: begin
        if (done) begin
          state_next = (elem_left == 3'd1) ? CGAP : EGAP;
        end
      end
      EGAP: begin
        if (done) begin
          state_next = MARK;
        end
      end
      CGAP: begin
        if (done) begin
          state_next = IDLE;
        end
      end
      WGAP: begin
        if (done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs that follow the current state directly
  always_comb begin
    busy       = (state != IDLE);
    char_ready = (state == IDLE);
  end

  // Number of units (minus one) the state being entered lasts; a mark's length depends on the element about to be sent
  always_comb begin
    next_dash   = (state == IDLE) ? rom_bits[4] : elem_bits[4];
    entry_units = 2'd0;
    case (state_next)
      MARK:    entry_units = next_dash ? 2'd2 : 2'd0;
      EGAP:    entry_units = 2'd0;
      CGAP:    entry_units = 2'd2;
      WGAP:    entry_units = 2'd3;
      default: entry_units = 2'd0;
    endcase
  end

  // Unit timer: reload on every state entry, then count ticks within a unit and units within the state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt <= '0;
      unit_cnt <= 2'd0;
    end else if (state_next != state) begin
      tick_cnt <= (state_next == IDLE) ? '0 : TICK_LAST;
      unit_cnt <= (state_next == IDLE) ? 2'd0 : entry_units;
    end else if (state != IDLE) begin
      if (tick_cnt == '0) begin
        tick_cnt <= TICK_LAST;
        unit_cnt <= unit_cnt - 2'd1;
      end else begin
        tick_cnt <= tick_cnt - 1'b1;
      end
    end
  end

  // Element shifter: load the pattern on accept, step to the next element each time a mark finishes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      elem_bits <= 5'b00000;
      elem_left <= 3'd0;
    end else if (accept && is_symbol) begin
      elem_bits <= rom_bits;
      elem_left <= rom_len;
    end else if (state == MARK && done) begin
      elem_bits <= {elem_bits[3:0], 1'b0};
      elem_left <= elem_left - 3'd1;
    end
  end

  // Registered LED and error pulse so both appear glitch-free one cycle after the decision
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led <= 1'b0;
      err <= 1'b0;
    end else begin
      led <= (state_next == MARK);
      err <= accept && !is_symbol && !is_space;
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: drives scripted and random characters into morse_keyer and
// compares every cycle against a queue-based timeline built from Morse strings.
module tb_morse_keyer;

  localparam int U = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic       led;
  logic       busy;
  logic       err;

  morse_keyer #(.UNIT_TICKS(U)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .char_valid(char_valid),
    .char_data(char_data),
    .char_ready(char_ready),
    .led(led),
    .busy(busy),
    .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic led;
    logic busy;
    logic ready;
    logic err;
  } exp_t;

  string letterCode [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                             ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                             "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digitCode [10] = '{"-----", ".----", "..---", "...--", "....-",
                            ".....", "-....", "--...", "---..", "----."};

  int   checks = 0;
  int   passes = 0;
  int   acceptCount = 0;
  exp_t q[$];
  exp_t scratch[$];
  exp_t cur = '{led: 1'b0, busy: 1'b0, ready: 1'b1, err: 1'b0};

  function automatic exp_t mk(input logic l, input logic b, input logic r, input logic e);
    exp_t x;
    x.led = l;
    x.busy = b;
    x.ready = r;
    x.err = e;
    return x;
  endfunction

  // 0 = unsupported, 1 = letter/digit (pattern returned), 2 = space
  function automatic int classify(input logic [7:0] c, output string pat);
    pat = "";
    if (c >= 8'h41 && c <= 8'h5A) begin
      pat = letterCode[int'(c) - 65];
      return 1;
    end
    if (c >= 8'h61 && c <= 8'h7A) begin
      pat = letterCode[int'(c) - 97];
      return 1;
    end
    if (c >= 8'h30 && c <= 8'h39) begin
      pat = digitCode[int'(c) - 48];
      return 1;
    end
    if (c == 8'h20) return 2;
    return 0;
  endfunction

  // Expected per-cycle timeline (cycles 1..N after accept) for one character
  function automatic void expand(input logic [7:0] c);
    string pat;
    int k;
    int n;
    scratch.delete();
    k = classify(c, pat);
    if (k == 2) begin
      for (int i = 0; i < 4*U; i++) scratch.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
    end else if (k == 1) begin
      for (int e = 0; e < pat.len(); e++) begin
        n = (pat[e] == 8'h2D) ? 3*U : U;
        for (int i = 0; i < n; i++) scratch.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
        if (e < pat.len() - 1) begin
          for (int i = 0; i < U; i++) scratch.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
        end
      end
      for (int i = 0; i < 3*U; i++) scratch.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
    end
  endfunction

  // Reference model: decides accepts from the driven inputs and plays out expected timelines
  always @(posedge CLK or negedge RST_N) begin
    string pat;
    int k;
    if (!RST_N) begin
      q.delete();
      cur = mk(1'b0, 1'b0, 1'b1, 1'b0);
    end else if (cur.ready && char_valid) begin
      acceptCount++;
      k = classify(char_data, pat);
      if (k == 0) begin
        cur = mk(1'b0, 1'b0, 1'b1, 1'b1);
      end else begin
        expand(char_data);
        q = scratch;
        cur = q.pop_front();
      end
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = mk(1'b0, 1'b0, 1'b1, 1'b0);
    end
  end

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s at %0t: wait bound expired", name, $time);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge CLK) begin
    checkOutput("led", int'(led), int'(cur.led));
    checkOutput("busy", int'(busy), int'(cur.busy));
    checkOutput("char_ready", int'(char_ready), int'(cur.ready));
    checkOutput("err", int'(err), int'(cur.err));
  end

  function automatic logic [7:0] pickChar();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 2) return 8'($urandom_range(65, 90));
    if (r <= 4) return 8'($urandom_range(97, 122));
    if (r <= 6) return 8'($urandom_range(48, 57));
    if (r == 7) return 8'h20;
    return 8'($urandom_range(0, 255));
  endfunction

  // Present c until the model records an accept; returns at the negedge of cycle 1
  task automatic applyStimulus(input logic [7:0] c, output logic err1, output logic ready1, output logic led1);
    int base;
    int n;
    base = acceptCount;
    n = 0;
    char_valid = 1'b1;
    char_data = c;
    while (acceptCount == base && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (acceptCount == base) failNow("accept");
    err1 = err;
    ready1 = char_ready;
    led1 = led;
    char_valid = 1'b0;
    char_data = 8'($urandom_range(0, 255));
  endtask

  // From cycle 1, count led-high cycles and the cycle where char_ready returns
  task automatic measure(output int readyAt, output int highs);
    int k;
    k = 1;
    highs = 0;
    while (!char_ready && k < 400) begin
      highs += int'(led);
      char_data = 8'($urandom_range(0, 255));
      @(negedge CLK);
      k++;
    end
    readyAt = k;
  endtask

  task automatic sendAndMeasure(input string name, input logic [7:0] c, input int expReady, input int expHigh);
    logic e1, r1, l1;
    int readyAt, highs;
    applyStimulus(c, e1, r1, l1);
    measure(readyAt, highs);
    checkOutput({name, "_ready_cycle"}, readyAt, expReady);
    checkOutput({name, "_led_high"}, highs, expHigh);
    checkOutput({name, "_err"}, int'(e1), 0);
  endtask

  task automatic wordGapTest();
    logic trace [0:199];
    int base, n, d, fall, rise;
    base = acceptCount;
    n = 0;
    char_valid = 1'b1;
    char_data = 8'h45;
    while (n < 200) begin
      @(negedge CLK);
      d = acceptCount - base;
      trace[n] = led;
      n++;
      if (d == 1) char_data = 8'h20;
      else if (d == 2) char_data = 8'h45;
      else if (d >= 3) begin
        char_valid = 1'b0;
        char_data = 8'($urandom_range(0, 255));
        if (cur.ready) break;
      end
    end
    if (n >= 200) failNow("word_gap_run");
    checkOutput("word_gap_accepts", acceptCount - base, 3);
    fall = -1;
    rise = -1;
    for (int i = 1; i < n; i++) begin
      if (fall < 0 && trace[i-1] && !trace[i]) fall = i;
      else if (fall >= 0 && rise < 0 && !trace[i-1] && trace[i]) rise = i;
    end
    checkOutput("word_gap_low_cycles", rise - fall, 30);
  endtask

  initial begin
    logic e1, r1, l1;
    int readyAt, highs;

    #1 RST_N = 1'b0;
    #2;
    checkOutput("reset_led", int'(led), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_ready", int'(char_ready), 1);

    expand(8'h45); checkOutput("model_len_E", scratch.size() + 1, 17);
    expand(8'h61); checkOutput("model_len_a", scratch.size() + 1, 33);
    expand(8'h30); checkOutput("model_len_0", scratch.size() + 1, 89);
    expand(8'h20); checkOutput("model_len_space", scratch.size() + 1, 17);
    expand(8'h23); checkOutput("model_len_hash", scratch.size() + 1, 1);

    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    sendAndMeasure("E", 8'h45, 17, 4);
    sendAndMeasure("a", 8'h61, 33, 16);
    sendAndMeasure("zero", 8'h30, 89, 60);
    wordGapTest();

    applyStimulus(8'h23, e1, r1, l1);
    checkOutput("hash_err", int'(e1), 1);
    checkOutput("hash_ready", int'(r1), 1);
    checkOutput("hash_led", int'(l1), 0);
    sendAndMeasure("T", 8'h54, 25, 12);

    applyStimulus(8'h54, e1, r1, l1);
    repeat (5) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("async_reset_led", int'(led), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    checkOutput("async_reset_ready", int'(char_ready), 1);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    sendAndMeasure("E_after_reset", 8'h45, 17, 4);

    for (int i = 0; i < 2500; i++) begin
      char_valid = ($urandom_range(0, 3) == 0);
      char_data = pickChar();
      @(negedge CLK);
    end
    char_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!cur.ready && n < 500) begin
        @(negedge CLK);
        n++;
      end
      if (!cur.ready) failNow("final_idle");
    end
    @(negedge CLK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Upstream source stage for the board LED outputs (PIN_12..PIN_15).
- Accepts ASCII characters over a valid/ready handshake and emits the Morse on/off key stream as a single LED drive bit, with standard unit timing derived from a clock-cycle prescaler.
- Replaces fixed hard-coded blink patterns with character-driven patterns.
- One instance per LED channel.

Parameters:
- UNIT_TICKS, 1600000, CLK cycles per Morse unit (100 ms at 16 MHz). Must be >= 2. Sim uses 4.
- CNT_W, $clog2(3*UNIT_TICKS+1), width of the internal tick counter. Derived; do not override.

Ports:
- CLK  input  1  16 MHz system clock.
- RST_N  input  1  asynchronous active-low reset.
- char_valid  input  1  char_data holds a character to send.
- char_data  input  8  ASCII code.
- char_ready  output  1  block can accept a character this cycle.
- led  output  1  key output. 1 = LED on. Registered.
- busy  output  1  high whenever not IDLE.
- err  output  1  one-cycle pulse when an unsupported character is accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE, led=0, busy=0, err=0, char_ready=1, all counters 0. led goes 0 immediately on RST_N falling, including mid-character.
- Accept: occurs on a rising CLK edge where char_valid and char_ready are both 1. char_data is captured at that edge. char_ready=1 only in IDLE, so it drops the cycle after accept.
- Supported characters:
  - 'A'-'Z' and 'a'-'z': lowercase maps to uppercase.
  - '0'-'9'.
  - ' ' (0x20).
- Encoding: combinational ROM giving length L (1..5) and 5 element bits, sent MSB-first, 1 = dash.
- Element durations:
  - Dot mark: 1 unit.
  - Dash mark: 3 units.
  - Intra-character gap between elements: 1 unit off.
  - After the last element: 3 units off (inter-character gap).
  - Space character: 4 units off with no mark. Combined with the preceding character's 3-unit gap, this gives the 7-unit word gap.
- Unsupported character:
  - Accepted normally; err=1 for exactly the cycle after accept.
  - No led activity and no gap.
  - Returns to IDLE with char_ready=1 the cycle after accept.
- FSM states: IDLE, MARK, EGAP, CGAP, WGAP.
  - IDLE --accept letter/digit--> MARK (first element). led=1 on the cycle after accept (latency 1).
  - IDLE --accept space--> WGAP.
  - IDLE --accept unsupported--> IDLE, with err pulse.
  - MARK --duration expired, elements remain--> EGAP.
  - MARK --duration expired, last element--> CGAP.
  - EGAP --1 unit--> MARK (next element).
  - CGAP --3 units--> IDLE.
  - WGAP --4 units--> IDLE.
- Timing: each state lasts exactly units*UNIT_TICKS cycles. The tick counter reloads on every state entry. The element index decrements per MARK exit.
- led is 1 only in MARK. busy = (state != IDLE).
- char_valid and char_data are ignored while not IDLE; they may change freely.
- Back-to-back: if char_valid is held high, the next accept occurs on the first IDLE cycle. That cycle is 1 extra cycle after CGAP/WGAP ends.
- Total cycles from accept to char_ready=1 again, U = UNIT_TICKS:
  - Character: 1 + U*(sum of marks + (L-1) + 3).
  - Space: 1 + 4U.
  - Unsupported: 1.

Test Plan:
- Reset then send 'E' (0x45), UNIT_TICKS=4 -> led=1 for cycles 1-4 after accept, 0 for 12 cycles, char_ready=1 at cycle 17. busy high cycles 1-16. err stays 0.
- Send 'a' (0x61) -> identical to 'A'. led high 4, low 4, high 12, low 12. char_ready back at cycle 33.
- Send '0' (0x30) -> five 12-cycle marks separated by 4-cycle gaps, then 12 low. char_ready back at cycle 89.
- Send "E E" with char_valid held high -> gap between the two E marks is 12+1+16+1 = 30 low cycles. Verify char_data changes while busy are ignored.
- Send '#' (0x23) -> err=1 for one cycle, led stays 0, char_ready=1 the next cycle. Then 'T' sends correctly (12 high, 12 low).
- Assert RST_N=0 mid-dash of 'T' -> led=0 immediately (async), busy=0. After release, char_ready=1 and a new 'E' produces the normal 4-high/12-low pattern.
